// File: rtl/piso_sched_ctrl_if.sv
// piso_sched_ctrl_if: requester-side words/requests plus the serial link outputs.
interface piso_sched_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*WIDTH-1:0]   data_in;
    logic [NUM_REQ-1:0]         gnt;
    logic                       serial_out;
    logic                       serial_valid;
    logic                       frame_start;
    logic                       frame_end;
    logic                       busy;
    logic [$clog2(NUM_REQ)-1:0] src_id;
    modport master (
        output req, data_in,
        input  gnt, serial_out, serial_valid, frame_start, frame_end, busy, src_id
    );
    modport slave (
        input  req, data_in,
        output gnt, serial_out, serial_valid, frame_start, frame_end, busy, src_id
    );
endinterface

// File: rtl/piso_sched_ctrl.sv
// piso_sched_ctrl: round-robin PISO scheduler; frames MSB-first words with start/end markers and an idle gap.
// Optional trailing even-parity bit when PISO_SCHED_PARITY_EN is defined.
module piso_sched_ctrl #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1
) (
    input logic clk,
    input logic rst_n,
    piso_sched_ctrl_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
`ifdef PISO_SCHED_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CW = $clog2(FLEN + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   word;
    logic [CW-1:0]      cnt;
    logic [3:0]         gcnt;
    logic [IW-1:0]      last_grant;
    logic [IW-1:0]      winner;
    logic [IW-1:0]      src_id;
    logic [NUM_REQ-1:0] gnt;
    logic               serial_out;
    logic               serial_valid;
    logic               frame_start;
    logic               frame_end;
    logic               busy;
`ifdef PISO_SCHED_PARITY_EN
    logic               par;
`endif

    function automatic logic [IW-1:0] rr(input logic [IW-1:0] last, input int k);
        return IW'((int'(last) + k) % NUM_REQ);
    endfunction

    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        winner = last_grant;
        for (int k = NUM_REQ; k >= 1; k--)
            if (bus.req[rr(last_grant, k)]) winner = rr(last_grant, k);
    end

    assign word = bus.data_in[winner*WIDTH +: WIDTH];

    // cnt counts bits already placed on serial_out in the current frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            shreg        <= '0;
            cnt          <= '0;
            gcnt         <= '0;
            last_grant   <= IW'(NUM_REQ - 1);
            gnt          <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            busy         <= 1'b0;
            src_id       <= '0;
`ifdef PISO_SCHED_PARITY_EN
            par          <= 1'b0;
`endif
        end else begin
            gnt         <= '0;
            frame_start <= 1'b0;
            case (state)
                IDLE: if (|bus.req) begin
                    state        <= SHIFT;
                    gnt          <= NUM_REQ'(1) << winner;
                    src_id       <= winner;
                    last_grant   <= winner;
                    shreg        <= word << 1;
                    serial_out   <= word[WIDTH-1];
                    serial_valid <= 1'b1;
                    frame_start  <= 1'b1;
                    busy         <= 1'b1;
                    cnt          <= CW'(1);
`ifdef PISO_SCHED_PARITY_EN
                    par          <= ^word;
`endif
                end
                SHIFT: if (int'(cnt) < FLEN) begin
`ifdef PISO_SCHED_PARITY_EN
                    serial_out <= (int'(cnt) == WIDTH) ? par : shreg[WIDTH-1];
`else
                    serial_out <= shreg[WIDTH-1];
`endif
                    shreg      <= shreg << 1;
                    cnt        <= cnt + CW'(1);
                    frame_end  <= int'(cnt) == FLEN - 1;
                end else begin
                    serial_out   <= 1'b0;
                    serial_valid <= 1'b0;
                    frame_end    <= 1'b0;
                    cnt          <= '0;
                    gcnt         <= 4'd1;
                    if (GAP_CYCLES > 0) begin
                        state <= GAP;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                GAP: if (int'(gcnt) >= GAP_CYCLES) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    gcnt  <= '0;
                end else begin
                    gcnt <= gcnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt          = gnt;
    assign bus.serial_out   = serial_out;
    assign bus.serial_valid = serial_valid;
    assign bus.frame_start  = frame_start;
    assign bus.frame_end    = frame_end;
    assign bus.busy         = busy;
    assign bus.src_id       = src_id;
endmodule

// File: tb/tb_piso_sched_ctrl.sv
// tb_piso_sched_ctrl: table-driven frame checks plus hand sequences for reset, zero-gap and parity cases.
module tb_piso_sched_ctrl;
`ifdef PISO_SCHED_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = 8 + PAR;
    localparam int P2 = 3 + PAR + 1;

    typedef struct {
        logic       rst;
        logic [3:0] set;
        logic [3:0] clr;
        logic [3:0] mid;
        int         idx;
        logic [7:0] word;
        int         per;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   last_g = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] words [4] = '{8'hA5, 8'h3C, 8'hF0, 8'h5A};
    logic [8:0] fr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    piso_sched_ctrl_if #(.NUM_REQ(4), .WIDTH(8)) bus ();
    piso_sched_ctrl_if #(.NUM_REQ(2), .WIDTH(3)) bus2 ();

    piso_sched_ctrl #(.NUM_REQ(4), .WIDTH(8), .GAP_CYCLES(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    piso_sched_ctrl #(.NUM_REQ(2), .WIDTH(3), .GAP_CYCLES(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus.data_in = {words[3], words[2], words[1], words[0]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0;
        bus2.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits for a grant, then checks the whole frame plus the gap/idle cycles that follow.
    task automatic run_frame(input string tag, input int idx, input logic [7:0] w, input logic [3:0] clr,
                             input logic [3:0] mid, input int per, output logic [8:0] f);
        int t = 0;
        logic [8:0] vm = '0, sm = '0, em = '0, gm = '0;
        logic [8:0] exp_f;
        while (bus.gnt == 4'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check({tag, " grant_wait"}, 32'(t < 40), 32'd1);
        check({tag, " gnt"}, bus.gnt, 32'(4'b1 << idx));
        check({tag, " src_id"}, bus.src_id, idx);
        if (per > 0) check({tag, " period"}, cyc - last_g, per);
        last_g = cyc;
        bus.req &= ~clr;
        f = '0;
        for (int i = 0; i < FL; i++) begin
            if (i == 3) bus.req |= mid;
            f = {f[7:0], bus.serial_out};
            vm[i] = bus.serial_valid;
            sm[i] = bus.frame_start;
            em[i] = bus.frame_end;
            gm[i] = |bus.gnt;
            @(negedge clk);
        end
        exp_f = (PAR != 0) ? {w, ^w} : {1'b0, w};
        check({tag, " data"}, f, exp_f);
        check({tag, " valid"}, vm, (1 << FL) - 1);
        check({tag, " start"}, sm, 1);
        check({tag, " end"}, em, 1 << (FL - 1));
        check({tag, " gnt_pulse"}, gm, 1);
        check({tag, " gap"}, {bus.serial_valid, bus.serial_out, bus.busy, |bus.gnt}, 4'b0010);
        if (bus.req == 4'b0) begin
            @(negedge clk);
            check({tag, " idle"}, {bus.busy, |bus.gnt, bus.src_id}, {2'b00, 2'(idx)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        vec_t vt [9];
        logic [14:0] v_act, o_act, g_act, v_exp, o_exp, g_exp;
        logic [2:0] w2;
        int t;
        vt[0] = '{1'b1, 4'b0001, 4'b0001, 4'b0000, 0, 8'hA5, 0};
        vt[1] = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 0, 8'hA5, 0};
        vt[2] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1, 8'h3C, 9 + FL - 8 + 1};
        vt[3] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2, 8'hF0, 9 + FL - 8 + 1};
        vt[4] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 3, 8'h5A, 9 + FL - 8 + 1};
        vt[5] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 0, 8'hA5, 9 + FL - 8 + 1};
        vt[6] = '{1'b1, 4'b0010, 4'b0010, 4'b1100, 1, 8'h3C, 0};
        vt[7] = '{1'b0, 4'b0000, 4'b0100, 4'b0000, 2, 8'hF0, 9 + FL - 8 + 1};
        vt[8] = '{1'b0, 4'b0000, 4'b1000, 4'b0000, 3, 8'h5A, 9 + FL - 8 + 1};
        bus.req = '0;
        bus2.req = '0;
        bus2.data_in = 6'b000_100;
        do_reset();
        check("reset_state", {bus.gnt, bus.serial_out, bus.serial_valid, bus.frame_start,
                              bus.frame_end, bus.busy, bus.src_id}, 0);
        for (int i = 0; i < 9; i++) begin
            if (vt[i].rst) do_reset();
            bus.req |= vt[i].set;
            run_frame($sformatf("vec%0d", i), vt[i].idx, vt[i].word, vt[i].clr, vt[i].mid, vt[i].per, fr);
        end
        // Reset in the middle of an all-ones frame, requester keeps asking.
        do_reset();
        words[0] = 8'hFF;
        bus.req = 4'b0001;
        t = 0;
        while (bus.gnt == 4'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("rst_mid grant_wait", 32'(t < 40), 32'd1);
        repeat (3) @(negedge clk);
        check("rst_mid bit4", {bus.serial_valid, bus.serial_out, bus.frame_end}, 3'b110);
        rst_n = 1'b0;
        #1;
        check("rst_mid async", {bus.gnt, bus.serial_out, bus.serial_valid, bus.frame_start,
                                bus.frame_end, bus.busy, bus.src_id}, 0);
        @(negedge clk);
        check("rst_mid held", {bus.serial_valid, bus.frame_end, bus.busy}, 0);
        rst_n = 1'b1;
        run_frame("rst_refr", 0, 8'hFF, 4'b0001, 4'b0000, 0, fr);
        // Zero-gap, 3-bit instance with continuous request.
        do_reset();
        w2 = 3'b100;
        bus2.req = 2'b01;
        t = 0;
        while (bus2.gnt == 2'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("w3 grant_wait", 32'(t < 40), 32'd1);
        v_act = '0; o_act = '0; g_act = '0; v_exp = '0; o_exp = '0; g_exp = '0;
        for (int c = 0; c < 3 * P2; c++) begin
            v_act[c] = bus2.serial_valid;
            o_act[c] = bus2.serial_out;
            g_act[c] = bus2.gnt[0];
            v_exp[c] = (c % P2) < 3 + PAR;
            o_exp[c] = ((c % P2) < 3) ? w2[2 - (c % P2)] : ((c % P2) == 3 && PAR != 0);
            g_exp[c] = (c % P2) == 0;
            @(negedge clk);
        end
        bus2.req = '0;
        check("w3 valid", v_act, v_exp);
        check("w3 data", o_act, o_exp);
        check("w3 gnt", g_act, g_exp);
`ifdef PISO_SCHED_PARITY_EN
        do_reset();
        words[0] = 8'h07;
        bus.req = 4'b0001;
        run_frame("par07", 0, 8'h07, 4'b0001, 4'b0000, 0, fr);
        check("par07 bits", fr, 9'b0000_0111_1);
        words[0] = 8'h03;
        bus.req = 4'b0001;
        run_frame("par03", 0, 8'h03, 4'b0001, 4'b0000, 0, fr);
        check("par03 bits", fr, 9'b0000_0011_0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/piso_sched_ctrl.md
# piso_sched_ctrl

Scheduler and sequencer for the parallel-in/serial-out shifter. Up to NUM_REQ requesters each present a parallel word with a request line. The block grants one requester at a time using round-robin arbitration, captures its word and shifts it out MSB-first. Each frame is delimited by start/end markers and followed by a programmable idle gap. It sits between the parallel producers and the single serial link.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- WIDTH, 8: bits per word, 2..32.
- GAP_CYCLES, 1: idle cycles after each frame, 0..15.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; held high until that requester's gnt pulse.
- data_in  in  NUM_REQ*WIDTH  word for requester i at bits [i*WIDTH +: WIDTH]; stable while req[i] is high.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- serial_out  out  1  serial data; 0 when serial_valid=0.
- serial_valid  out  1  high while a frame bit is on serial_out.
- frame_start  out  1  high on the first bit of a frame.
- frame_end  out  1  high on the last bit of a frame.
- busy  out  1  high in every state except IDLE.
- src_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.

## Operation
- The FSM has three states: IDLE, SHIFT and GAP.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise, at the clock edge: select the winner, load shreg <= data_in[winner], set gnt[winner]=1 and src_id <= winner, set bit counter = 0, move to SHIFT.
- Arbitration is round-robin:
  - Search starts at (last_grant+1) mod NUM_REQ.
  - After reset, last_grant = NUM_REQ-1, so index 0 has highest priority.
  - last_grant updates only on a grant.
- SHIFT:
  - serial_out = shreg[WIDTH-1]; shreg shifts left by one each cycle.
  - serial_valid=1.
  - frame_start=1 when the counter is 0.
  - frame_end=1 on the final bit.
  - After the final bit: go to GAP if GAP_CYCLES>0, else go to IDLE.
- GAP:
  - Count GAP_CYCLES cycles with serial_valid=0 and busy=1, then go to IDLE.
- req is ignored outside IDLE. A new request arriving mid-frame waits for the next IDLE.
- gnt is high only in the first SHIFT cycle. The requester must drop req (or present a new word) before the next IDLE sample.
- Simultaneous requests: exactly one grant per IDLE sample. The remaining requesters keep req high and are served in rotation.
- All outputs are registered.
- Reset is asynchronous. The following clear immediately:
  - state=IDLE
  - gnt=0, serial_out=0, serial_valid=0, frame_start=0, frame_end=0, busy=0, src_id=0
  - shreg=0, counters=0, last_grant=NUM_REQ-1
- Reset mid-frame discards the frame with no frame_end. A requester still holding req is re-granted after rst_n rises.

## Timing
- Grant latency: req high while in IDLE at edge E0 gives gnt, frame_start and the first bit in the cycle after E0.
- Frame length is WIDTH cycles (WIDTH+1 with parity).
- Frame-to-frame period with continuous requests is WIDTH + GAP_CYCLES + 1 cycles, including the IDLE sampling cycle.
- frame_start and frame_end are both asserted only if the frame is one bit long, which WIDTH≥2 prevents.
- busy falls in the IDLE cycle. It never falls between the final bit and the end of GAP.
- src_id changes only on a grant. It holds across GAP and IDLE.

## Configuration
- PISO_SCHED_PARITY_EN defined:
  - One even-parity bit (XOR of the captured word) is appended after the data bits, with serial_valid=1.
  - frame_end moves to the parity bit; frame length is WIDTH+1.
  - Period is WIDTH + GAP_CYCLES + 2.
- PISO_SCHED_PARITY_EN undefined:
  - No parity logic; frame length is WIDTH.

## Test plan
- Single word, defaults: req[0]=1, data_in word0=8'hA5. Expect:
  - gnt=4'b0001 for one cycle.
  - serial_out 1,0,1,0,0,1,0,1 with serial_valid high for 8 cycles.
  - frame_start on bit 1, frame_end on bit 8.
  - src_id=0, then 1 GAP cycle, then busy=0.
- Round-robin: all four req held high with distinct words. Grants go 0,1,2,3,0, spaced 10 cycles apart, and each frame carries the matching word.
- Late request mid-frame: req[3] rises during the SHIFT of requester 1, with req[2] also high. req[3] is ignored until IDLE; the next grant goes to 2, then 3.
- Reset mid-frame: rst_n low during bit 4 of 8'hFF. All outputs go 0 immediately with no frame_end. After release, with req[0] still held, gnt[0] fires and a full 8'hFF frame follows.
- GAP_CYCLES=0, WIDTH=3: word 3'b100 with req held continuously. Expect frames 1,0,0 every 4 cycles, with exactly 1 non-valid cycle between frames.
- PISO_SCHED_PARITY_EN defined:
  - Word 8'h07 gives 9 valid bits 0,0,0,0,0,1,1,1,1, with frame_end on the parity bit (1).
  - Word 8'h03 gives parity bit 0.
